// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: serializer states and default baud divisor.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 100 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered occupancy count.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_wrAccept;
  logic             w_rdAccept;

  assign empty      = (r_count == '0);
  assign full       = (r_count == CNT_W'(DEPTH));
  assign w_rdAccept = rd_en & ~empty;
  assign w_wrAccept = wr_en & (~full | w_rdAccept);
  assign rd_data    = r_mem[r_head];
  assign count      = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) r_tail <= r_tail + 1'b1;
      if (w_rdAccept) r_head <= r_head + 1'b1;
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && w_wrAccept) r_mem[r_tail] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a registered tx output.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baudNext;
  logic [2:0]        r_bitIdx;
  logic [2:0]        w_bitNext;
  logic [7:0]        r_shift;
  logic [7:0]        w_shiftNext;
  logic              r_tx;
  logic              w_txNext;
  logic              w_pop;
  logic [7:0]        w_fifoData;
  logic [CNT_W-1:0]  w_count;
  logic              w_haveByte;
  logic              w_baudDone;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_fifoData),
    .full    (full),
    .empty   (empty),
    .count   (w_count)
  );

  assign w_haveByte = (w_count != '0);
  assign w_baudDone = (r_baud == BAUD_LAST);
  assign busy       = (r_state != IDLE);
  assign tx         = r_tx;

  // Serializer state register; tx is registered so it lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
    end
  end

  // Next-state, baud timing, FIFO pop and line level for the current state.
  always_comb begin
    w_stateNext = r_state;
    w_baudNext  = r_baud + 1'b1;
    w_bitNext   = r_bitIdx;
    w_shiftNext = r_shift;
    w_txNext    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baudNext = '0;
        if (w_haveByte) begin
          w_pop       = 1'b1;
          w_shiftNext = w_fifoData;
          w_stateNext = START;
        end
      end
      START: begin
        w_txNext = 1'b0;
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_bitNext   = '0;
          w_stateNext = DATA;
        end
      end
      DATA: begin
        w_txNext = r_shift[r_bitIdx];
        if (w_baudDone) begin
          w_baudNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitNext = r_bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        w_txNext = 1'b1;
        if (w_baudDone) begin
          w_baudNext = '0;
          if (w_haveByte) begin
            w_pop       = 1'b1;
            w_shiftNext = w_fifoData;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_baudNext  = '0;
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: three instances cover the fast-baud, shallow-FIFO and real-baud cases.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA_n, wrEnA, fullA, emptyA, busyA, txA;
  logic [7:0] wrDataA;
  logic       rstB_n, wrEnB, fullB, emptyB, busyB, txB;
  logic [7:0] wrDataB;
  logic       rstC_n, wrEnC, fullC, emptyC, busyC, txC;
  logic [7:0] wrDataC;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dutA (
    .clk(clk), .rst_n(rstA_n), .wr_en(wrEnA), .wr_data(wrDataA),
    .full(fullA), .empty(emptyA), .busy(busyA), .tx(txA)
  );

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dutB (
    .clk(clk), .rst_n(rstB_n), .wr_en(wrEnB), .wr_data(wrDataB),
    .full(fullB), .empty(emptyB), .busy(busyB), .tx(txB)
  );

  uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(8)) dutC (
    .clk(clk), .rst_n(rstC_n), .wr_en(wrEnC), .wr_data(wrDataC),
    .full(fullC), .empty(emptyC), .busy(busyC), .tx(txC)
  );

  int checks = 0;
  int passes = 0;

  logic [399:0] recVec;
  int           recIdx;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic txOf(input int sel);
    case (sel)
      0:       return txA;
      1:       return txB;
      default: return txC;
    endcase
  endfunction

  // Advance one cycle and record the selected instance's tx line.
  task automatic stepRec(input int sel);
    tick();
    recVec[recIdx] = txOf(sel);
    recIdx++;
  endtask

  // Expected line waveform: 'lead' idle-high cycles, then 8N1 frames of the given bytes.
  function automatic logic [399:0] makeExpected(input logic [63:0] bytes, input int nBytes,
                                                input int lead, input int cpb);
    logic [399:0] v;
    int idx;
    v = '1;
    for (int f = 0; f < nBytes; f++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < cpb; c++) begin
          idx = lead + f * 10 * cpb + b * cpb + c;
          if (b == 0)      v[idx] = 1'b0;
          else if (b == 9) v[idx] = 1'b1;
          else             v[idx] = bytes[8 * f + b - 1];
        end
    return v;
  endfunction

  function automatic int countDiff(input logic [399:0] exp, input int len);
    int e = 0;
    for (int i = 0; i < len; i++)
      if (recVec[i] !== exp[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
    wrEnA = 1'b1; wrDataA = 8'h5A;
    wrEnB = 1'b0; wrDataB = 8'h00;
    wrEnC = 1'b0; wrDataC = 8'h00;
    tick(); tick();
    checks++; if (txA !== 1'b1) $display("[TB] FAIL reset_tx got %b want 1", txA); else passes++;
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busyA); else passes++;
    checks++; if (emptyA !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", emptyA); else passes++;
    checks++; if (fullA !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", fullA); else passes++;
    rstA_n = 1'b1; rstB_n = 1'b1; rstC_n = 1'b1;
    wrEnA = 1'b0;
    tick();
    checks++; if (emptyA !== 1'b1) $display("[TB] FAIL reset_write_ignored empty got %b want 1", emptyA); else passes++;
    checks++; if (txA !== 1'b1) $display("[TB] FAIL reset_idle_tx got %b want 1", txA); else passes++;
  endtask

  task automatic test_single();
    int busyCnt;
    int d;
    recIdx = 0;
    wrDataA = 8'h55; wrEnA = 1'b1;
    stepRec(0);
    wrEnA = 1'b0;
    checks++; if (emptyA !== 1'b0) $display("[TB] FAIL single_queued empty got %b want 0", emptyA); else passes++;
    checks++; if (txA !== 1'b1) $display("[TB] FAIL single_first_cycle_tx got %b want 1", txA); else passes++;
    stepRec(0);
    checks++; if (busyA !== 1'b1) $display("[TB] FAIL single_busy_start got %b want 1", busyA); else passes++;
    checks++; if (emptyA !== 1'b1) $display("[TB] FAIL single_empty_after_pop got %b want 1", emptyA); else passes++;
    busyCnt = 1;
    while (recIdx < 42) begin
      stepRec(0);
      if (busyA === 1'b1) busyCnt++;
    end
    d = countDiff(makeExpected(64'h55, 1, 2, 4), 42);
    checks++; if (d != 0) $display("[TB] FAIL single_waveform bad cycles got %0d want 0", d); else passes++;
    checks++; if (busyCnt != 40) $display("[TB] FAIL single_busy_len got %0d want 40", busyCnt); else passes++;
    checks++; if (busyA !== 1'b0 || txA !== 1'b1)
      $display("[TB] FAIL single_end busy/tx got %b%b want 01", busyA, txA); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expB [2];
    logic [7:0] dec;
    int d;
    expB[0] = 8'hA5; expB[1] = 8'h3C;
    recIdx = 0;
    wrDataA = 8'hA5; wrEnA = 1'b1;
    stepRec(0);
    wrDataA = 8'h3C;
    stepRec(0);
    wrEnA = 1'b0;
    checks++; if (emptyA !== 1'b0) $display("[TB] FAIL b2b_second_queued empty got %b want 0", emptyA); else passes++;
    while (recIdx < 82) stepRec(0);
    d = countDiff(makeExpected({48'h0, 8'h3C, 8'hA5}, 2, 2, 4), 82);
    checks++; if (d != 0) $display("[TB] FAIL b2b_waveform bad cycles got %0d want 0", d); else passes++;
    checks++; if ({recVec[42], recVec[41]} !== 2'b01)
      $display("[TB] FAIL b2b_no_gap start/stop got %b want 01", {recVec[42], recVec[41]}); else passes++;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 8; b++) dec[b] = recVec[2 + f * 40 + (b + 1) * 4 + 2];
      checks++; if (dec !== expB[f])
        $display("[TB] FAIL b2b_decode%0d got %h want %h", f, dec, expB[f]); else passes++;
    end
    checks++; if (busyA !== 1'b0 || emptyA !== 1'b1)
      $display("[TB] FAIL b2b_end busy/empty got %b%b want 01", busyA, emptyA); else passes++;
  endtask

  task automatic test_overflow();
    int d;
    recIdx = 0;
    wrEnB = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wrDataB = 8'(i + 1);
      stepRec(1);
      if (i == 4) begin
        checks++; if (fullB !== 1'b1) $display("[TB] FAIL ovf_full_after_5th got %b want 1", fullB); else passes++;
      end
    end
    wrEnB = 1'b0;
    checks++; if (fullB !== 1'b1) $display("[TB] FAIL ovf_full_after_drop got %b want 1", fullB); else passes++;
    while (recIdx < 202) stepRec(1);
    d = countDiff(makeExpected({24'h0, 40'h0504030201}, 5, 2, 4), 202);
    checks++; if (d != 0) $display("[TB] FAIL ovf_waveform bad cycles got %0d want 0", d); else passes++;
    checks++; if (busyB !== 1'b0 || emptyB !== 1'b1)
      $display("[TB] FAIL ovf_end busy/empty got %b%b want 01", busyB, emptyB); else passes++;
  endtask

  task automatic test_full_pop_write();
    logic [7:0] seq [5];
    int d;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;
    recIdx = 0;
    wrEnB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wrDataB = seq[i];
      stepRec(1);
    end
    wrEnB = 1'b0;
    while (recIdx < 41) stepRec(1);
    checks++; if (fullB !== 1'b1) $display("[TB] FAIL fpw_full_before_pop got %b want 1", fullB); else passes++;
    wrDataB = 8'h77; wrEnB = 1'b1;
    stepRec(1);
    wrEnB = 1'b0;
    checks++; if (fullB !== 1'b1) $display("[TB] FAIL fpw_full_after_pop_write got %b want 1", fullB); else passes++;
    while (recIdx < 242) stepRec(1);
    d = countDiff(makeExpected({16'h0, 48'h775544332211}, 6, 2, 4), 242);
    checks++; if (d != 0) $display("[TB] FAIL fpw_waveform bad cycles got %0d want 0", d); else passes++;
    checks++; if (busyB !== 1'b0 || emptyB !== 1'b1)
      $display("[TB] FAIL fpw_end busy/empty got %b%b want 01", busyB, emptyB); else passes++;
  endtask

  task automatic test_reset_midframe();
    int d;
    recIdx = 0;
    wrDataA = 8'hFF; wrEnA = 1'b1;
    stepRec(0);
    wrEnA = 1'b0;
    while (recIdx < 19) stepRec(0);
    checks++; if (busyA !== 1'b1) $display("[TB] FAIL rst_mid_busy got %b want 1", busyA); else passes++;
    rstA_n = 1'b0; wrEnA = 1'b1; wrDataA = 8'hAA;
    stepRec(0);
    checks++; if (txA !== 1'b1) $display("[TB] FAIL rst_mid_tx got %b want 1", txA); else passes++;
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL rst_mid_busy_clr got %b want 0", busyA); else passes++;
    checks++; if (emptyA !== 1'b1) $display("[TB] FAIL rst_mid_empty got %b want 1", emptyA); else passes++;
    rstA_n = 1'b1; wrEnA = 1'b0;
    tick();
    checks++; if (txA !== 1'b1 || busyA !== 1'b0)
      $display("[TB] FAIL rst_mid_after tx/busy got %b%b want 10", txA, busyA); else passes++;
    recIdx = 0;
    wrDataA = 8'h00; wrEnA = 1'b1;
    stepRec(0);
    wrEnA = 1'b0;
    while (recIdx < 42) stepRec(0);
    d = countDiff(makeExpected(64'h00, 1, 2, 4), 42);
    checks++; if (d != 0) $display("[TB] FAIL rst_mid_clean_frame bad cycles got %0d want 0", d); else passes++;
  endtask

  task automatic test_real_baud();
    logic [7:0] rxByte;
    logic [7:0] ref_byte;
    logic       startBit, stopBit, expBit;
    int lat, errs, bitNo;
    ref_byte = 8'h0D;
    rxByte = 8'h00; startBit = 1'b1; stopBit = 1'b0; errs = 0;
    wrDataC = ref_byte; wrEnC = 1'b1;
    tick();
    wrEnC = 1'b0;
    lat = 1;
    while (txC !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 3) $display("[TB] FAIL real_start_latency got %0d want 3", lat); else passes++;
    if (txC === 1'b0) begin
      for (int c = 0; c < 8680; c++) begin
        if (c > 0) tick();
        bitNo = c / 868;
        if (bitNo == 0)      expBit = 1'b0;
        else if (bitNo == 9) expBit = 1'b1;
        else                 expBit = ref_byte[bitNo - 1];
        if (txC !== expBit) errs++;
        if ((c % 868) == 434) begin
          if (bitNo == 0)      startBit = txC;
          else if (bitNo == 9) stopBit = txC;
          else                 rxByte[bitNo - 1] = txC;
        end
      end
      checks++; if (errs != 0) $display("[TB] FAIL real_bit_widths bad cycles got %0d want 0", errs); else passes++;
      checks++; if (rxByte !== ref_byte) $display("[TB] FAIL real_decode got %h want %h", rxByte, ref_byte); else passes++;
      checks++; if ({startBit, stopBit} !== 2'b01)
        $display("[TB] FAIL real_framing start/stop got %b want 01", {startBit, stopBit}); else passes++;
      tick();
      checks++; if (busyC !== 1'b0) $display("[TB] FAIL real_end_busy got %b want 0", busyC); else passes++;
    end else begin
      checks++;
      $display("[TB] FAIL real_start_timeout tx got %b want 0", txC);
    end
  endtask

  initial begin
    rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
    wrEnA = 1'b0; wrEnB = 1'b0; wrEnC = 1'b0;
    wrDataA = 8'h00; wrDataB = 8'h00; wrDataC = 8'h00;
    recVec = '1; recIdx = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_write();
    test_reset_midframe();
    test_real_baud();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte-FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, byte-write strobe from the CPU IO path.
REQ-006 SHALL have port wr_data, input, 8, byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port empty, output, 1, FIFO holds 0 bytes.
REQ-009 SHALL have port busy, output, 1, serializer not in IDLE.
REQ-010 SHALL have port tx, output, 1, serial line (idle high) feeding the top-level Tx pin.

Function
REQ-011 SHALL accept a write on every cycle with wr_en=1 and full=0; wr_data is stored at the tail.
REQ-012 SHALL discard a write with wr_en=1 and full=1; FIFO contents and count unchanged.
REQ-013 SHALL handle a same-cycle write and pop: count is unchanged, and the write is accepted even when full=1 in that cycle.
REQ-014 SHALL keep a count of 0..FIFO_DEPTH; head and tail pointers wrap modulo FIFO_DEPTH; full and empty derive combinationally from the registered count.
REQ-015 SHALL run a serializer FSM with states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1. When empty=0, pop the head byte into the shift register and enter START on the next edge.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-018 DATA: tx=shift[bit index], sent LSB first; each bit lasts CLKS_PER_BIT cycles; after bit 7 enter STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles. Then pop and re-enter START directly if empty=0, otherwise return to IDLE; back-to-back frames have no extra idle gap.
REQ-020 SHALL drive tx from a register (no combinational glitch). The first start-bit cycle SHALL appear 2 cycles after the accepting write edge into an empty FIFO with FSM in IDLE.
REQ-021 SHALL count cycles with a baud counter of width clog2(CLKS_PER_BIT); the counter resets to 0 on every state or bit change.
REQ-022 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-023 A frame SHALL be exactly 10*CLKS_PER_BIT cycles (start + 8 data + stop).

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL clear count, head and tail, enter IDLE, clear the baud counter and bit index, and set tx=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame; tx=1 from the cycle after the reset edge; queued bytes are lost.
REQ-026 Output values after reset SHALL be: tx=1, busy=0, empty=1, full=0. Writes during rst_n=0 SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (2-bit) and the default baud constant (868); FIFO_DEPTH stays a module parameter.
REQ-028 The FIFO SHALL be one sub-module, sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH, ports wr_en/wr_data/rd_en/rd_data/full/empty/count); the serializer FSM lives in uart_tx.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-029 Write 0x55 once from idle -> tx reads, 4 cycles per bit, 0,1,0,1,0,1,0,1,0,1; busy high for 40 cycles; empty=1 after the pop.
REQ-030 Write 0xA5, 0x3C on consecutive cycles -> two frames back-to-back, 80 cycles total, no idle-high gap between the STOP of the first frame and the START of the second; decoded bytes are 0xA5 then 0x3C.
REQ-031 FIFO_DEPTH=4: write 6 bytes 0x01..0x06 in consecutive cycles while the first frame is sending -> full=1 after the 5th write (one byte popped). Byte 0x06 is dropped and 0x01..0x05 are transmitted in order.
REQ-032 With full=1 and a pop occurring, assert wr_en with 0x77 in the same cycle -> byte accepted, full stays 1, and 0x77 is transmitted last.
REQ-033 Assert rst_n=0 for 1 cycle at bit 3 of a frame of 0xFF -> tx=1 the next cycle; busy=0, empty=1; a new write of 0x00 afterwards produces a clean frame.
REQ-034 CLKS_PER_BIT=868: send 0x0D -> each bit is exactly 868 cycles, and a behavioural UART receiver model decodes 0x0D with no framing error.
